// File: rtl/sdp_ram_fifo_ctrl.sv
// +------------------------------------------------------------------------+
// | Module  : sdp_ram_fifo_ctrl (+ simple_dual_port_ram)                   |
// | Purpose : First-word-fall-through valid/ready FIFO built on a simple   |
// |           dual-port RAM with registered read. A 2-entry output buffer  |
// |           hides the read latency; RAM addresses are steered so the     |
// |           RAM's registered address-equality bypass never leaks data.   |
// | Revision: 1.0  initial release                                         |
// +------------------------------------------------------------------------+
`default_nettype none

// Port A write, port B registered read. When the two addresses match,
// the registered write data is returned instead of the array contents.
module simple_dual_port_ram #(
    parameter int WIDTH      = 64,
    parameter int DEPTH      = 512,
    parameter int LOG2_DEPTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr,
    input  logic [LOG2_DEPTH-1:0] addr_a,
    input  logic [WIDTH-1:0]      d,
    input  logic [LOG2_DEPTH-1:0] addr_b,
    output logic [WIDTH-1:0]      q
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_d;
    logic             r_byp;

    // Array write, registered read and registered bypass select
    always_ff @(posedge clk) begin
        if (wr) begin
            r_mem[addr_a] <= d;
        end
        r_q   <= r_mem[addr_b];
        r_d   <= d;
        r_byp <= (addr_a == addr_b);
    end

    assign q = r_byp ? r_d : r_q;

endmodule

module sdp_ram_fifo_ctrl #(
    parameter int WIDTH      = 64,
    parameter int DEPTH      = 512,
    parameter int LOG2_DEPTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [LOG2_DEPTH+1:0] count,
    output logic                  empty
);

    localparam logic [LOG2_DEPTH:0]   c_RAM_FULL = (LOG2_DEPTH+1)'(DEPTH);
    localparam logic [LOG2_DEPTH-1:0] c_PTR_ONE  = (LOG2_DEPTH)'(1);

    logic [LOG2_DEPTH-1:0] r_wr_ptr;
    logic [LOG2_DEPTH-1:0] r_rd_ptr;
    logic [LOG2_DEPTH:0]   r_ram_cnt;
    logic                  r_inflight;
    logic [WIDTH-1:0]      r_ob0;
    logic [WIDTH-1:0]      r_ob1;
    logic [1:0]            r_ob_cnt;
    logic [LOG2_DEPTH+1:0] r_count;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_issue;
    logic [2:0]            w_occ;
    logic                  w_ram_wr;
    logic [LOG2_DEPTH-1:0] w_addr_a;
    logic [LOG2_DEPTH-1:0] w_addr_b;
    logic [WIDTH-1:0]      w_ram_q;
    logic [1:0]            w_ob_kept;
    logic [WIDTH-1:0]      w_ob0_nxt;
    logic [WIDTH-1:0]      w_ob1_nxt;
    logic [1:0]            w_ob_cnt_nxt;
    logic [LOG2_DEPTH:0]   w_ram_cnt_nxt;
    logic [LOG2_DEPTH+1:0] w_count_nxt;

    assign in_ready  = (r_ram_cnt != c_RAM_FULL);
    assign out_valid = (r_ob_cnt != 2'd0);
    assign out_data  = r_ob0;
    assign count     = r_count;
    assign empty     = (r_count == '0);

    assign w_push = in_valid & in_ready;
    assign w_pop  = out_valid & out_ready;

    // A read may issue only if the buffer plus the read in flight, less
    // this cycle's pop, leaves room for the returning word. ram_cnt is
    // sampled before this cycle's push, so a word is never read in the
    // cycle it is written.
    assign w_occ   = {1'b0, r_ob_cnt} + {2'b00, r_inflight};
    assign w_issue = (r_ram_cnt != '0) && (w_occ < (3'd2 + {2'b00, w_pop}));

    // On idle write cycles port A points one past the read address so the
    // bypass comparator cannot match and substitute unwritten data.
    assign w_ram_wr = w_push;
    assign w_addr_a = w_push ? r_wr_ptr : (r_rd_ptr + c_PTR_ONE);
    assign w_addr_b = r_rd_ptr;

    assign w_ram_cnt_nxt = r_ram_cnt + {{LOG2_DEPTH{1'b0}}, w_push}
                                     - {{LOG2_DEPTH{1'b0}}, w_issue};
    assign w_count_nxt   = r_count + {{(LOG2_DEPTH+1){1'b0}}, w_push}
                                   - {{(LOG2_DEPTH+1){1'b0}}, w_pop};

    simple_dual_port_ram #(
        .WIDTH      (WIDTH),
        .DEPTH      (DEPTH),
        .LOG2_DEPTH (LOG2_DEPTH)
    ) u_ram (
        .clk    (clk),
        .wr     (w_ram_wr),
        .addr_a (w_addr_a),
        .d      (in_data),
        .addr_b (w_addr_b),
        .q      (w_ram_q)
    );

    // Output buffer: shift on pop, then append the returning RAM word at the tail
    always_comb begin
        w_ob0_nxt    = r_ob0;
        w_ob1_nxt    = r_ob1;
        w_ob_kept    = r_ob_cnt;
        if (w_pop) begin
            w_ob0_nxt = r_ob1;
            w_ob_kept = r_ob_cnt - 2'd1;
        end
        w_ob_cnt_nxt = w_ob_kept;
        if (r_inflight) begin
            if (w_ob_kept == 2'd0) begin
                w_ob0_nxt = w_ram_q;
            end else begin
                w_ob1_nxt = w_ram_q;
            end
            w_ob_cnt_nxt = w_ob_kept + 2'd1;
        end
    end

    // Pointer, occupancy and output-buffer state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_ram_cnt  <= '0;
            r_inflight <= 1'b0;
            r_ob0      <= '0;
            r_ob1      <= '0;
            r_ob_cnt   <= 2'd0;
            r_count    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_issue) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            r_inflight <= w_issue;
            r_ram_cnt  <= w_ram_cnt_nxt;
            r_ob0      <= w_ob0_nxt;
            r_ob1      <= w_ob1_nxt;
            r_ob_cnt   <= w_ob_cnt_nxt;
            r_count    <= w_count_nxt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sdp_ram_fifo_ctrl.sv
// +------------------------------------------------------------------------+
// | Module  : tb_sdp_ram_fifo_ctrl                                         |
// | Purpose : Self-checking bench for sdp_ram_fifo_ctrl, DEPTH=512 and 4.  |
// | Revision: 1.0  initial release                                         |
// +------------------------------------------------------------------------+
`default_nettype none

module tb_sdp_ram_fifo_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    // DEPTH = 512 instance
    logic        iv5 = 1'b0, or5 = 1'b0;
    logic [63:0] id5 = '0;
    logic        in_ready5, out_valid5, empty5;
    logic [63:0] out_data5;
    logic [10:0] count5;

    // DEPTH = 4 instance
    logic        iv4 = 1'b0, or4 = 1'b0;
    logic [63:0] id4 = '0;
    logic        in_ready4, out_valid4, empty4;
    logic [63:0] out_data4;
    logic [3:0]  count4;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sdp_ram_fifo_ctrl #(.WIDTH(64), .DEPTH(512)) u_dut5 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv5), .in_ready(in_ready5), .in_data(id5),
        .out_valid(out_valid5), .out_ready(or5), .out_data(out_data5),
        .count(count5), .empty(empty5)
    );

    sdp_ram_fifo_ctrl #(.WIDTH(64), .DEPTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv4), .in_ready(in_ready4), .in_data(id4),
        .out_valid(out_valid4), .out_ready(or4), .out_data(out_data4),
        .count(count4), .empty(empty4)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference models: plain word queues ----------------
    logic [63:0] q5[$];
    logic [63:0] q4[$];
    int push5 = 0, pop5 = 0;

    // Record handshakes as the DUTs see them at the clock edge
    always @(posedge clk) begin
        if (!rst_n) begin
            q5.delete();
            q4.delete();
        end else begin
            if (out_valid5 && or5 && q5.size() != 0) begin void'(q5.pop_front()); pop5++; end
            if (iv5 && in_ready5) begin q5.push_back(id5); push5++; end
            if (out_valid4 && or4 && q4.size() != 0) void'(q4.pop_front());
            if (iv4 && in_ready4) q4.push_back(id4);
        end
    end

    // Every cycle: occupancy, head word and flow-control bounds against the model
    always @(negedge clk) begin
        if (rst_n) begin
            chk("m512_count", 64'(count5), 64'(q5.size()));
            chk("m512_empty", 64'(empty5), 64'(q5.size() == 0));
            if (q5.size() == 0) chk("m512_valid_when_empty", 64'(out_valid5), 64'd0);
            else if (out_valid5) chk("m512_head_data", out_data5, q5[0]);
            if (q5.size() >= 514) chk("m512_ready_when_full", 64'(in_ready5), 64'd0);
            if (q5.size() < 512)  chk("m512_ready_when_room", 64'(in_ready5), 64'd1);

            chk("m4_count", 64'(count4), 64'(q4.size()));
            chk("m4_empty", 64'(empty4), 64'(q4.size() == 0));
            if (q4.size() == 0) chk("m4_valid_when_empty", 64'(out_valid4), 64'd0);
            else if (out_valid4) chk("m4_head_data", out_data4, q4[0]);
            if (q4.size() >= 6) chk("m4_ready_when_full", 64'(in_ready4), 64'd0);
            if (q4.size() < 4)  chk("m4_ready_when_room", 64'(in_ready4), 64'd1);
        end
    end

    // ---------------- cycle-exact vector table for DEPTH = 4 ----------------
    typedef struct {
        logic        iv;
        logic [63:0] d;
        logic        ordy;
        logic        e_ov;
        logic [63:0] e_od;
        logic [3:0]  e_cnt;
        logic        e_ir;
        logic        e_empty;
    } vec_t;

    vec_t tbl[15];

    task automatic measure_latency(input logic [63:0] val, input string nm);
        int k;
        @(negedge clk); iv5 = 1'b1; id5 = val; or5 = 1'b1;
        @(negedge clk); iv5 = 1'b0;
        k = 1;
        while (!out_valid5 && k < 20) begin @(negedge clk); k++; end
        chk({nm, "_latency"}, 64'(k), 64'd3);
        chk({nm, "_data"}, out_data5, val);
        @(negedge clk);
        chk({nm, "_empty_after_pop"}, 64'(empty5), 64'd1);
    endtask

    initial begin
        int k;
        int base_push, base_pop;

        // outputs checked before driving the vector's inputs for the next edge
        tbl[0]  = '{1'b1, 64'd1, 1'b0, 1'b0, 64'd0, 4'd0, 1'b1, 1'b1};
        tbl[1]  = '{1'b1, 64'd2, 1'b0, 1'b0, 64'd0, 4'd1, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 64'd3, 1'b0, 1'b0, 64'd0, 4'd2, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 64'd4, 1'b0, 1'b1, 64'd1, 4'd3, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 64'd5, 1'b0, 1'b1, 64'd1, 4'd4, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 64'd6, 1'b0, 1'b1, 64'd1, 4'd5, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 64'd7, 1'b1, 1'b1, 64'd1, 4'd6, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 64'd7, 1'b0, 1'b1, 64'd2, 4'd5, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 64'd0, 1'b1, 1'b1, 64'd2, 4'd6, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 64'd0, 1'b1, 1'b1, 64'd3, 4'd5, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 64'd0, 1'b1, 1'b1, 64'd4, 4'd4, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 64'd0, 1'b1, 1'b1, 64'd5, 4'd3, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 64'd0, 1'b1, 1'b1, 64'd6, 4'd2, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 64'd0, 1'b1, 1'b1, 64'd7, 4'd1, 1'b1, 1'b0};
        tbl[14] = '{1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 4'd0, 1'b1, 1'b1};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            chk($sformatf("vec%0d_out_valid", i), 64'(out_valid4), 64'(tbl[i].e_ov));
            if (tbl[i].e_ov) chk($sformatf("vec%0d_out_data", i), out_data4, tbl[i].e_od);
            chk($sformatf("vec%0d_count", i), 64'(count4), 64'(tbl[i].e_cnt));
            chk($sformatf("vec%0d_in_ready", i), 64'(in_ready4), 64'(tbl[i].e_ir));
            chk($sformatf("vec%0d_empty", i), 64'(empty4), 64'(tbl[i].e_empty));
            iv4 = tbl[i].iv; id4 = tbl[i].d; or4 = tbl[i].ordy;
        end

        // ---- asynchronous reset mid-stream with 7 words held ----
        or5 = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk); iv5 = 1'b1; id5 = 64'(100 + i);
        end
        @(negedge clk); iv5 = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_pre_count", 64'(count5), 64'd7);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid5), 64'd0);
        chk("rst_empty", 64'(empty5), 64'd1);
        chk("rst_count", 64'(count5), 64'd0);
        chk("rst_in_ready", 64'(in_ready5), 64'd1);
        chk("rst_out_data", out_data5, 64'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        measure_latency(64'hA, "rst_push");

        // ---- single word latency ----
        measure_latency(64'h1234, "single");

        // ---- streaming: 2000 words, one per cycle after a 3-cycle fill ----
        base_pop = pop5;
        for (int c = 0; c < 2003; c++) begin
            @(negedge clk); iv5 = (c < 2000); id5 = 64'(c); or5 = 1'b1;
        end
        @(negedge clk); iv5 = 1'b0;
        chk("stream_pops", 64'(pop5 - base_pop), 64'd2000);
        chk("stream_empty", 64'(empty5), 64'd1);

        // ---- fill with the consumer stalled ----
        base_push = push5;
        base_pop  = pop5;
        or5 = 1'b0;
        k = 0;
        while (k < 2000) begin
            @(negedge clk);
            if (!in_ready5) break;
            iv5 = 1'b1; id5 = 64'(push5 - base_push);
            k++;
        end
        chk("fill_bound", 64'(k < 2000), 64'd1);
        chk("fill_accepted", 64'(push5 - base_push), 64'd514);
        chk("fill_count", 64'(count5), 64'd514);
        id5 = 64'd514;
        @(negedge clk);
        chk("fill_hold_ready", 64'(in_ready5), 64'd0);

        // ---- full boundary: one pop lets one more word in ----
        or5 = 1'b1;
        @(negedge clk); or5 = 1'b0;
        chk("full_pop_ready", 64'(in_ready5), 64'd1);
        chk("full_pop_count", 64'(count5), 64'd513);
        @(negedge clk); iv5 = 1'b0;
        chk("full_refill_count", 64'(count5), 64'd514);
        chk("full_refill_ready", 64'(in_ready5), 64'd0);
        chk("full_refill_push", 64'(push5 - base_push), 64'd515);

        // ---- drain in order ----
        or5 = 1'b1;
        k = 0;
        while (!empty5 && k < 2000) begin @(negedge clk); k++; end
        chk("drain_empty", 64'(empty5), 64'd1);
        chk("drain_pops", 64'(pop5 - base_pop), 64'd515);

        // ---- random traffic on both depths ----
        fork
            begin
                int pv, po;
                pv = 50; po = 50;
                for (int c = 0; c < 20000; c++) begin
                    @(negedge clk);
                    if (c % 500 == 0) begin pv = $urandom_range(30, 90); po = $urandom_range(30, 90); end
                    iv5 = ($urandom_range(0, 99) < pv);
                    id5 = {$urandom(), $urandom()};
                    or5 = ($urandom_range(0, 99) < po);
                end
            end
            begin
                int pv, po;
                pv = 50; po = 50;
                for (int c = 0; c < 20000; c++) begin
                    @(negedge clk);
                    if (c % 500 == 0) begin pv = $urandom_range(30, 90); po = $urandom_range(30, 90); end
                    iv4 = ($urandom_range(0, 99) < pv);
                    id4 = {$urandom(), $urandom()};
                    or4 = ($urandom_range(0, 99) < po);
                end
            end
        join
        @(negedge clk);
        iv5 = 1'b0; iv4 = 1'b0; or5 = 1'b1; or4 = 1'b1;
        k = 0;
        while ((!empty5 || !empty4) && k < 2000) begin @(negedge clk); k++; end
        chk("rand_drain_empty512", 64'(empty5), 64'd1);
        chk("rand_drain_empty4", 64'(empty4), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
